norm_lut_writer: RTL and testbench

//  Writable normalisation LUT: the load (write) side of the LUT that the fixed ROM path only reads.

---
 rtl/norm_lut_writer.sv | 106 ++++++++++
 tb/tb_norm_lut_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_lut_writer.sv
// Runtime-writable normalisation LUT: streamed load port plus a
// registered read port that behaves like the fixed ROM.
module norm_lut_writer #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 6,
    parameter string TYPE       = "DISTRIBUTED"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  load_busy,
    output logic                  load_done,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int ROM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_remaining;

    logic                  w_beat;
    logic [ADDR_WIDTH:0]   w_count_clamp;

    assign wr_ready  = (r_state == S_LOAD);
    assign load_busy = (r_state == S_LOAD);
    assign load_done = (r_state == S_DONE);

    // Reset must not let a pending beat land in the array.
    assign w_beat        = wr_valid && wr_ready && !reset;
    assign w_count_clamp = (load_count > DEPTH_W) ? DEPTH_W : load_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_addr   <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        if (load_count != '0) begin
                            r_wr_addr   <= load_base;
                            r_remaining <= w_count_clamp;
                            r_state     <= S_LOAD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_wr_addr   <= r_wr_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == 1)
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-first array: the read samples the old word on a same-edge write.
    generate
        if (TYPE == "BLOCK") begin : g_block
            (* ram_style = "block" *)
            logic [DATA_WIDTH-1:0] r_mem [ROM_DEPTH];

            always_ff @(posedge clk) begin
                if (w_beat)
                    r_mem[r_wr_addr] <= wr_data;
                if (reset)
                    data_out <= '0;
                else if (enable)
                    data_out <= r_mem[address];
            end
        end else begin : g_dist
            (* ram_style = "distributed" *)
            logic [DATA_WIDTH-1:0] r_mem [ROM_DEPTH];

            always_ff @(posedge clk) begin
                if (w_beat)
                    r_mem[r_wr_addr] <= wr_data;
                if (reset)
                    data_out <= '0;
                else if (enable)
                    data_out <= r_mem[address];
            end
        end
    endgenerate

endmodule

// File: tb/tb_norm_lut_writer.sv
// Scoreboard bench for norm_lut_writer: directed loads, reads,
// wrap, clamp, stall, reset abort and read/write collision.
module tb_norm_lut_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_count;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        load_busy;
    logic        load_done;
    logic [5:0]  address;
    logic        enable;
    logic [15:0] data_out;

    norm_lut_writer dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_base  (load_base),
        .load_count (load_count),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .address    (address),
        .enable     (enable),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          beats = 0;
    bit          rd_pend = 1'b0;
    logic [15:0] exp_rd[$];
    int          exp_done[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Edge-side bookkeeping: sampled before the DUT updates.
    always @(posedge clk) begin
        cyc++;
        rd_pend = enable;
        if (wr_valid && wr_ready)
            beats++;
    end

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd: unexpected read data %0h", data_out);
            end else begin
                chk("rd_data", data_out, exp_rd.pop_front());
            end
        end
        if (load_done) begin
            if (exp_done.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else begin
                chk("done_cycle", cyc, exp_done.pop_front());
            end
        end else if (exp_done.size() != 0 && exp_done[0] < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL done: missing pulse, got none expected cycle %0d",
                     exp_done.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int base, input int cnt);
        load_base  = 6'(base);
        load_count = 7'(cnt);
        load_start = 1'b1;
        if (cnt == 0)
            exp_done.push_back(cyc + 1);
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input bit last);
        wr_valid = 1'b1;
        wr_data  = d;
        if (last)
            exp_done.push_back(cyc + 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int a, input logic [15:0] e);
        address = 6'(a);
        enable  = 1'b1;
        exp_rd.push_back(e);
        tick();
        enable = 1'b0;
    endtask

    int b0;

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        wr_data    = '0;
        wr_valid   = 1'b0;
        address    = '0;
        enable     = 1'b0;

        // Reset state and reads under reset
        for (int i = 0; i < 4; i++)
            rd(i, 16'h0000);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_busy", load_busy, 0);
        reset = 1'b0;
        tick();

        // Zero-count load: no writes, done only
        b0 = beats;
        start(10, 0);
        tick();
        tick();
        chk("zero_cnt_beats", beats - b0, 0);

        // Oversized count clamps to a full-depth load
        b0 = beats;
        start(0, 100);
        chk("clamp_busy", load_busy, 1);
        for (int i = 0; i < 64; i++)
            beat(16'h1000 + 16'(i), i == 63);
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        tick();
        wr_valid = 1'b0;
        chk("clamp_beats", beats - b0, 64);
        rd(0, 16'h1000);
        rd(63, 16'h103F);
        rd(10, 16'h100A);

        // Back-to-back three-word load at base 4
        b0 = beats;
        start(4, 3);
        beat(16'h00A1, 0);
        beat(16'h00A2, 0);
        beat(16'h00A3, 1);
        tick();
        chk("t2_beats", beats - b0, 3);
        rd(4, 16'h00A1);
        rd(5, 16'h00A2);
        rd(6, 16'h00A3);

        // Wrap past the top with a stalling source
        b0 = beats;
        start(62, 4);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                beat(16'h00C0 + 16'(i / 2), i == 6);
            else
                tick();
        end
        chk("t3_beats", beats - b0, 4);
        chk("t3_busy", load_busy, 0);
        rd(62, 16'h00C0);
        rd(63, 16'h00C1);
        rd(0, 16'h00C2);
        rd(1, 16'h00C3);
        rd(2, 16'h1002);

        // Reset mid-load: partial write stays, no done pulse
        start(5, 3);
        beat(16'h0055, 0);
        reset = 1'b1;
        tick();
        chk("t5_wr_ready", wr_ready, 0);
        chk("t5_busy", load_busy, 0);
        reset = 1'b0;
        tick();
        rd(5, 16'h0055);
        rd(6, 16'h00A3);

        // Reset beats a simultaneous load_start
        reset      = 1'b1;
        load_start = 1'b1;
        load_base  = 6'd20;
        load_count = 7'd5;
        tick();
        reset      = 1'b0;
        load_start = 1'b0;
        tick();
        chk("rst_vs_start_busy", load_busy, 0);

        // Same-edge read and write: read-first
        start(4, 1);
        wr_valid = 1'b1;
        wr_data  = 16'h00BB;
        address  = 6'd4;
        enable   = 1'b1;
        exp_rd.push_back(16'h00A1);
        exp_done.push_back(cyc + 1);
        tick();
        wr_valid = 1'b0;
        exp_rd.push_back(16'h00BB);
        tick();
        enable  = 1'b0;
        address = 6'd0;
        tick();
        tick();
        chk("hold_data", data_out, 16'h00BB);

        tick();
        tick();
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
